// File: rtl/jt12_cic_pkg.sv
// Shared types and constants for the JT12 CIC interpolator control slice.
package jt12_cic_pkg;

  localparam int unsigned PHASE_W  = 4;
  localparam int unsigned RATE_MIN = 2;
  localparam int unsigned RATE_MAX = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/jt12_cic_phase.sv
// Interpolation phase counter and drain-length counter for the CIC control.
module jt12_cic_phase
  import jt12_cic_pkg::*;
#(
  parameter int unsigned RATE   = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               drain_tick,
  output logic               wrap,
  output logic [PHASE_W-1:0] phase,
  output logic               drain_done
);

  localparam int unsigned DRAIN_LEN = STAGES * RATE;
  localparam int unsigned DW        = $clog2(DRAIN_LEN);
  localparam logic [PHASE_W-1:0] LAST  = PHASE_W'(RATE - 1);
  localparam logic [DW-1:0]      DLAST = DW'(DRAIN_LEN - 1);

  logic [DW-1:0] dcnt;

  assign wrap       = tick && (phase == LAST);
  assign drain_done = drain_tick && (dcnt == DLAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      dcnt  <= '0;
    end else begin
      if (drain_done || wrap) phase <= '0;
      else if (tick)          phase <= phase + 1'b1;
      if (drain_done)      dcnt <= '0;
      else if (drain_tick) dcnt <= dcnt + 1'b1;
    end
  end

endmodule

// File: rtl/jt12_cic_ctrl.sv
// CIC interpolator control: input buffer, run/drain FSM, comb/integrator enables.
// Optional 8-bit saturating underrun counter with JT12_CIC_UNDERRUN_CNT_EN.
module jt12_cic_ctrl
  import jt12_cic_pkg::*;
#(
  parameter int          W      = 16,
  parameter int unsigned RATE   = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic                en,
  input  logic                snd_valid,
  input  logic signed [W-1:0] snd_in,
  output logic                snd_ready,
  output logic signed [W-1:0] comb_din,
  output logic                comb_cen,
  output logic                integ_cen,
  output logic [PHASE_W-1:0]  phase,
  output logic                underrun
`ifdef JT12_CIC_UNDERRUN_CNT_EN
  ,
  output logic [7:0]          underrun_cnt
`endif
);

  if (RATE < RATE_MIN || RATE > RATE_MAX) begin : g_bad_rate
    $error("jt12_cic_ctrl: RATE out of range");
  end

  state_t              state;
  logic                buf_full;
  logic signed [W-1:0] buf_data;
  logic                tick, at_zero, load, drain_tick, accept;
  logic                wrap, drain_done;

  // rst gates the enables so the reset edge itself never pulses the chains
  assign tick       = cen && (state != IDLE) && !rst;
  assign at_zero    = (phase == '0);
  assign load       = tick && (state == RUN) && at_zero && en;
  // the phase-0 tick that sees en low is already the first drain tick
  assign drain_tick = tick && ((state == DRAIN) || ((state == RUN) && at_zero && !en));
  assign snd_ready  = !buf_full;
  assign accept     = snd_valid && snd_ready;
  assign integ_cen  = tick;
  assign comb_cen   = tick && at_zero;

  jt12_cic_phase #(
    .RATE   (RATE),
    .STAGES (STAGES)
  ) u_phase (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .drain_tick (drain_tick),
    .wrap       (wrap),
    .phase      (phase),
    .drain_done (drain_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      buf_full <= 1'b0;
      buf_data <= '0;
      comb_din <= '0;
      underrun <= 1'b0;
    end else begin
      if (accept) buf_data <= snd_in;
      buf_full <= accept || (buf_full && !load);
      if (load) begin
        comb_din <= buf_full ? buf_data : '0;
        if (!buf_full) underrun <= 1'b1;
      end else if (drain_tick && at_zero) begin
        comb_din <= '0;
      end
      case (state)
        IDLE:    if (cen && en && buf_full) state <= RUN;
        RUN:     if (drain_tick) state <= DRAIN;
        DRAIN:   if (drain_done && wrap) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JT12_CIC_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                          underrun_cnt <= '0;
    else if (load && !buf_full && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
  end
`endif

endmodule

// File: doc/jt12_cic_ctrl.md
JT12_CIC_CTRL -- requirements
Module: jt12_cic_ctrl

Interface
REQ-001 SHALL have parameter W, default 16, sample width in bits.
REQ-002 SHALL have parameter RATE, default 4, interpolation factor; legal range 2..16.
REQ-003 SHALL have parameter STAGES, default 2, comb/integrator pair count; sets the drain length.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cen  input  1  output-rate tick; one-clk pulse.
REQ-007 SHALL have port en  input  1  run request; low requests stop with drain.
REQ-008 SHALL have ports snd_valid  input  1, snd_in  input  W signed, snd_ready  output  1; valid/ready sample input.
REQ-009 SHALL have port comb_din  output  W signed  sample presented to the comb chain.
REQ-010 SHALL have ports comb_cen  output  1 and integ_cen  output  1  enables for the comb and integrator chains.
REQ-011 SHALL have ports phase  output  4  current interpolation phase, and underrun  output  1  sticky starvation flag.

Function
REQ-012 SHALL hold a one-entry input buffer, with snd_ready = !buf_full; a transfer occurs on clk when snd_valid && snd_ready.
REQ-013 SHALL implement states IDLE, RUN and DRAIN.
REQ-014 IDLE: comb_cen=0, integ_cen=0, phase=0; SHALL go to RUN on the first cen with en=1 and buf_full=1.
REQ-015 RUN: every cen SHALL pulse integ_cen in the same clk and advance phase 0..RATE-1, wrapping to 0.
REQ-016 RUN, cen with phase==0: comb_cen SHALL pulse in the same clk, and comb_din SHALL take the buffer value on the next clk (comb sees the new sample on the following comb_cen).
REQ-017 When consume and accept coincide in the same clk, the buffer SHALL end full with the newly accepted sample; no sample is lost or duplicated.
REQ-018 Underrun: on phase 0 in RUN with buffer empty, comb_din SHALL load 0 and underrun SHALL set; it stays set until rst.
REQ-019 en=0 in RUN SHALL move to DRAIN at the next phase-0 cen.
REQ-020 DRAIN SHALL load zeros into comb_din, keep RUN cadence, and run exactly STAGES*RATE cen ticks; it then SHALL go to IDLE with phase=0.
REQ-021 en=1 during DRAIN SHALL be ignored until IDLE is reached.
REQ-022 snd_ready SHALL stay governed by the buffer in every state; the buffer is not flushed by DRAIN.
REQ-023 A cen with en=0 in IDLE SHALL have no effect.

Reset
REQ-024 rst SHALL force state=IDLE, phase=0, buf_full=0, comb_din=0, comb_cen=0, integ_cen=0, underrun=0, and drain counter=0.
REQ-025 rst mid-RUN or mid-DRAIN SHALL discard the buffered sample, take effect on the next edge, and produce no enable pulse on that edge.

Configuration
REQ-026 With JT12_CIC_UNDERRUN_CNT_EN defined, SHALL add output underrun_cnt (8 bits), which increments once per underrun event, saturates at 255 and is cleared by rst.
REQ-027 Without JT12_CIC_UNDERRUN_CNT_EN, the port and counter SHALL be absent, and all other behaviour is identical.

Structure
REQ-028 Package jt12_cic_pkg SHALL hold the state enum (IDLE/RUN/DRAIN), the phase width constant (4), and the RATE legality bounds.
REQ-029 The phase and drain counting SHALL be one sub-module, jt12_cic_phase: cen in, wrap/phase/drain_done out.
REQ-030 Everything else SHALL remain in jt12_cic_ctrl.

Verification
REQ-031 Reset then push 0x1234 with en=1 and RATE=4 -> first cen moves the FSM to RUN, comb_cen fires at phase 0, and the next clk comb_din=0x1234; integ_cen fires on each of 4 cens, phase sequence 0,1,2,3,0.
REQ-032 Stream 8 samples back-to-back with a new sample offered on every phase-0 clk -> no underrun, and comb_din sequence equals the input exactly.
REQ-033 Withhold a sample at one phase 0 -> comb_din=0 for that period, underrun=1 and stays 1; with the macro, underrun_cnt=1.
REQ-034 Drop en at phase 2 with STAGES=2, RATE=4 -> DRAIN begins at the next phase 0 and lasts exactly 8 cens of zero input, then IDLE with no further enables.
REQ-035 Assert rst mid-RUN with buffer full -> the next clk shows all outputs at reset values and snd_ready=1.
REQ-036 Force 300 underruns with the macro defined -> underrun_cnt saturates at 255.
